alu_result_buffer: RTL

Downstream writeback stage for the 32-bit ALU. Each cycle it can accept one `{aluop, res_high, res_low}` result with a valid/ready handshake. It updates the architectural HI/LO registers in acceptance order and queues the result in a small first-word-fall-through FIFO for the consumer, so the ALU never stalls on a slow consumer until the FIFO is full. Illegal opcodes are dropped and reported through a sticky flag.

---
 rtl/alu_result_buffer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/alu_result_buffer.sv
`timescale 1ns/1ps
// Writeback buffer for the ALU: updates architectural HI/LO on accept and queues
// each legal result in a first-word-fall-through FIFO; illegal opcodes raise a sticky flag.
module alu_result_buffer #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [3:0]                 in_aluop,
  input  logic [WIDTH-1:0]           in_res_high,
  input  logic [WIDTH-1:0]           in_res_low,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [3:0]                 out_aluop,
  output logic [WIDTH-1:0]           out_high,
  output logic [WIDTH-1:0]           out_low,
  output logic [WIDTH-1:0]           hi_reg,
  output logic [WIDTH-1:0]           lo_reg,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       illegal_op,
  input  logic                       clear_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 4 + 2 * WIDTH;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  // Bit 1: opcode writes HI, bit 0: opcode writes LO; zero means illegal.
  function automatic logic [1:0] op_class(input logic [3:0] op);
    logic [1:0] cls;
    case (op)
      4'd0, 4'd1, 4'd4, 4'd5, 4'd6, 4'd9, 4'd10, 4'd11: cls = 2'b11;
      4'd12:                                             cls = 2'b01;
      default:                                           cls = 2'b00;
    endcase
    return cls;
  endfunction

  logic [EW-1:0]    mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             err_q, err_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [1:0]       cls_s;
  logic             accept_s;
  logic             push_s;
  logic             pop_s;

  // Handshake decode and next-state for pointers, occupancy, HI/LO and error flag.
  always_comb begin
    cls_s       = op_class(in_aluop);
    accept_s    = in_valid & in_ready_q;
    push_s      = accept_s & (cls_s != 2'b00);
    pop_s       = out_valid_q & out_ready;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    err_d       = err_q;

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (push_s && cls_s[1]) begin
      hi_d = in_res_high;
    end else begin
      hi_d = hi_q;
    end

    if (push_s && cls_s[0]) begin
      lo_d = in_res_low;
    end else begin
      lo_d = lo_q;
    end

    // Set wins over a coincident clear.
    if (accept_s && (cls_s == 2'b00)) begin
      err_d = 1'b1;
    end else if (clear_err) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end

    in_ready_d  = (count_d != FULL_C);
    out_valid_d = (count_d != CW'(0));
  end

  // Control and architectural state with asynchronous reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // FIFO storage; contents are don't-care after reset, so no reset here.
  always_ff @(posedge clock) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= {in_aluop, in_res_high, in_res_low};
    end
  end

  assign {out_aluop, out_high, out_low} = mem_q[rd_ptr_q];
  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign hi_reg     = hi_q;
  assign lo_reg     = lo_q;
  assign count      = count_q;
  assign illegal_op = err_q;

endmodule
